shift_cmd_queue: RTL
====================

Name: shift_cmd_queue

Overview:
Buffered command front-end and result capture stage for barrel_shifter_8bit. Accepts shift commands {data, shift amount, mode} over a valid/ready handshake into a DEPTH-entry FIFO. Presents the head entry to the combinational shifter and registers the shifter result into an output slot with its own valid/ready handshake. Gives the combinational shifter back-pressure, buffering and a registered output so it can sit in a pipelined datapath.

Parameters:
WIDTH, 8, data width; must match shifter data_in/data_out.
SW, 3, shift-amount width; must equal log2(WIDTH).
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
in_valid  in  1  upstream command valid.
in_ready  out  1  queue can accept; equals (count != DEPTH).
in_data  in  WIDTH  operand.
in_smt  in  SW  shift amount.
in_mode  in  2  shift mode, passed to the shifter unchanged.
sh_data_in  out  WIDTH  to shifter data_in.
sh_smt  out  SW  to shifter smt.
sh_mode  out  2  to shifter mode.
sh_data_out  in  WIDTH  from shifter data_out (combinational result).
out_valid  out  1  registered result valid.
out_ready  in  1  downstream accepts result.
out_data  out  WIDTH  registered shifter result.
out_smt  out  SW  echo of the command's smt.
out_mode  out  2  echo of the command's mode.
count  out  log2(DEPTH)+1  FIFO occupancy, excluding the output slot.

Behaviour:
- Reset (rst_n=0 at a clk edge): wr_ptr, rd_ptr, count=0; out_valid=0; out_data, out_smt, out_mode=0. Reset has priority over all handshakes. Reset mid-operation discards all queued and held commands. FIFO storage is not cleared.
- Push: in_valid && in_ready at an edge writes {in_data,in_smt,in_mode} at wr_ptr. wr_ptr then increments modulo DEPTH.
- sh_* outputs: while count>0, they drive the head entry at rd_ptr straight from storage registers, with no combinational path from in_*. While count==0, they drive all zeros.
- load = (count>0) && (!out_valid || out_ready).
- On load at an edge:
  - out_data <= sh_data_out, and out_smt/out_mode <= head fields.
  - out_valid <= 1.
  - rd_ptr increments modulo DEPTH.
- Consume without load: out_valid && out_ready && !load sets out_valid <= 0.
- Output slot holds out_* stable while out_valid && !out_ready.
- Occupancy: count changes by +1 on push only, -1 on load only, and is unchanged on simultaneous push and load. A push while full is impossible because in_ready=0. There is no write-through bypass, so a command pushed into an empty queue appears on sh_* the next cycle.
- Latency: command accepted at edge N → on sh_* during cycle N+1 → out_valid=1 after edge N+1. This is 2 cycles. Throughput is 1 command/cycle when out_ready is held high.
- Order: strict FIFO. Results leave in acceptance order.
- Pointers wrap modulo DEPTH. The full/empty decision uses count only.
- out_ready is ignored while out_valid=0. in_valid with in_ready=0 has no effect; upstream must hold the command.

Test Plan:
- Reset then single command: push data=8'b10101010, smt=3, mode=2'b00 → sh_data_in=8'hAA, sh_smt=3, sh_mode=0 one cycle later. out_valid=1 two cycles after accept. out_data equals the shifter's output for that input, out_smt=3, out_mode=0. count returns to 0.
- Fill with out_ready=0: push 4 commands (8'hAA/2/01, 8'hF0/1/10, 8'hD5/3/11, 8'h01/7/00) → the first moves to the output slot. After the 5th accepted push count=4 and in_ready=0. A further in_valid is not accepted and out_* are held.
- Drain: raise out_ready → results appear one per cycle in push order and each matches the scoreboard (reference shifter evaluation). count steps 4,3,2,1,0. in_ready returns to 1 after the first load.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with random fields → one result per cycle after a 2-cycle fill. count stays ≤1 and there are no drops or duplicates.
- Simultaneous push and load at count=2 → count stays 2 and ordering is preserved.
- Reset mid-stream: assert rst_n=0 for one edge with count=3 and out_valid=1 → next cycle count=0, out_valid=0, out_data=0, sh_* all zero. A subsequent push behaves as in the first scenario.

Source files
------------

// File: rtl/shift_cmd_queue.sv
// rtl/shift_cmd_queue.sv - command FIFO and registered result slot around an external combinational barrel shifter
module shift_cmd_queue #(
  parameter int WIDTH = 8,
  parameter int SW    = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SW-1:0]            in_smt,
  input  logic [1:0]               in_mode,
  output logic [WIDTH-1:0]         sh_data_in,
  output logic [SW-1:0]            sh_smt,
  output logic [1:0]               sh_mode,
  input  logic [WIDTH-1:0]         sh_data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SW-1:0]            out_smt,
  output logic [1:0]               out_mode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [SW-1:0]    mem_smt  [DEPTH];
  logic [1:0]       mem_mode [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          load;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign load     = !empty && (!out_valid || out_ready);

  // Head is read straight from storage, so the shifter never sees in_* combinationally.
  assign sh_data_in = empty ? '0 : mem_data[rd_ptr];
  assign sh_smt     = empty ? '0 : mem_smt[rd_ptr];
  assign sh_mode    = empty ? '0 : mem_mode[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_smt[wr_ptr]  <= in_smt;
      mem_mode[wr_ptr] <= in_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_smt   <= '0;
      out_mode  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (load) begin
        out_data  <= sh_data_out;
        out_smt   <= sh_smt;
        out_mode  <= sh_mode;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + AW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
